// File: rtl/rob_param.sv
// Parametrised in-order reorder buffer: one allocation, two writeback ports and
// one in-order retirement per cycle, with a store release handshake and mispredict flush.
module rob_param #(
  parameter int DEPTH  = 32,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int NAME_W = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic [NAME_W-1:0] alloc_rd,
  input  logic              alloc_is_store,
  input  logic              alloc_is_br,
  input  logic              alloc_pred,
  input  logic              wb0_valid,
  input  logic [TAG_W-1:0]  wb0_tag,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb0_taken,
  input  logic [ADDR_W-1:0] wb0_npc,
  input  logic              wb1_valid,
  input  logic [TAG_W-1:0]  wb1_tag,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              commit_valid,
  output logic [NAME_W-1:0] commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              store_req,
  output logic [TAG_W-1:0]  store_tag,
  input  logic              store_ack,
  output logic              flush,
  output logic [ADDR_W-1:0] flush_pc,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0]   DEPTH_C = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

  logic [DEPTH-1:0]  busy_q, ready_q, is_store_q, is_br_q, pred_q, taken_q;
  logic [NAME_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] npc_q  [DEPTH];

  logic [TAG_W-1:0]  head_q, tail_q;
  logic [TAG_W:0]    count_q, count_d;
  logic              commit_valid_q, flush_q;
  logic [NAME_W-1:0] commit_rd_q;
  logic [DATA_W-1:0] commit_data_q;
  logic [TAG_W-1:0]  commit_tag_q;
  logic [ADDR_W-1:0] flush_pc_q;

  logic head_ok, mispredict, normal_retire, store_retire, retire, alloc_fire;

  // Handshakes: alloc transfers on alloc_valid && alloc_ready at a rising edge with
  // rdy high; a store is released on store_req && store_ack at such an edge.
  assign head_ok       = busy_q[head_q] && ready_q[head_q];
  assign mispredict    = head_ok && !is_store_q[head_q] && is_br_q[head_q] &&
                         (taken_q[head_q] != pred_q[head_q]);
  assign normal_retire = head_ok && !is_store_q[head_q];
  assign store_retire  = head_ok && is_store_q[head_q] && store_ack;
  assign retire        = normal_retire || store_retire;
  assign alloc_ready   = (count_q < DEPTH_C) && !mispredict;
  assign alloc_fire    = alloc_valid && alloc_ready;

  always_comb begin
    count_d = count_q;
    if (alloc_fire && !retire)      count_d = count_q + CNT_ONE;
    else if (!alloc_fire && retire) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q         <= '0;
      ready_q        <= '0;
      is_store_q     <= '0;
      is_br_q        <= '0;
      pred_q         <= '0;
      taken_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
        npc_q[i]  <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else if (rdy) begin
      commit_valid_q <= normal_retire;
      flush_q        <= mispredict;
      if (normal_retire) begin
        commit_rd_q   <= rd_q[head_q];
        commit_data_q <= data_q[head_q];
        commit_tag_q  <= head_q;
      end
      if (mispredict) begin
        // Everything younger than the branch is wrong-path work.
        flush_pc_q <= npc_q[head_q];
        busy_q     <= '0;
        ready_q    <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
      end else begin
        // wb0 is applied last so it wins a same-tag collision.
        if (wb1_valid && busy_q[wb1_tag]) begin
          ready_q[wb1_tag] <= 1'b1;
          data_q[wb1_tag]  <= wb1_data;
        end
        if (wb0_valid && busy_q[wb0_tag]) begin
          ready_q[wb0_tag] <= 1'b1;
          data_q[wb0_tag]  <= wb0_data;
          taken_q[wb0_tag] <= wb0_taken;
          npc_q[wb0_tag]   <= wb0_npc;
        end
        if (retire) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + TAG_ONE;
        end
        if (alloc_fire) begin
          busy_q[tail_q]     <= 1'b1;
          ready_q[tail_q]    <= 1'b0;
          rd_q[tail_q]       <= alloc_rd;
          is_store_q[tail_q] <= alloc_is_store;
          is_br_q[tail_q]    <= alloc_is_br;
          pred_q[tail_q]     <= alloc_pred;
          taken_q[tail_q]    <= 1'b0;
          tail_q             <= tail_q + TAG_ONE;
        end
        count_q <= count_d;
      end
    end else begin
      commit_valid_q <= 1'b0;
      flush_q        <= 1'b0;
    end
  end

  assign alloc_tag    = tail_q;
  assign store_req    = head_ok && is_store_q[head_q];
  assign store_tag    = head_q;
  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_data  = commit_data_q;
  assign commit_tag   = commit_tag_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param (DEPTH=8): directed vector table, hand sequences for the
// multi-cycle corners and a random run against a queue-based reference model.
`timescale 1ns/1ps
module tb_rob_param;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
  logic        alloc_valid, alloc_ready, alloc_is_store, alloc_is_br, alloc_pred;
  logic [2:0]  alloc_tag, wb0_tag, wb1_tag, commit_tag, store_tag;
  logic [4:0]  alloc_rd, commit_rd;
  logic        wb0_valid, wb0_taken, wb1_valid, commit_valid, store_req, store_ack, flush, empty;
  logic [31:0] wb0_data, wb0_npc, wb1_data, commit_data, flush_pc;
  logic [3:0]  count;

  rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NAME_W(5), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_rd(alloc_rd), .alloc_is_store(alloc_is_store), .alloc_is_br(alloc_is_br),
    .alloc_pred(alloc_pred),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data), .wb0_taken(wb0_taken),
    .wb0_npc(wb0_npc),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_tag(commit_tag), .store_req(store_req), .store_tag(store_tag),
    .store_ack(store_ack), .flush(flush), .flush_pc(flush_pc), .count(count), .empty(empty)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: program-order queue ----------------
  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] npc;
    bit          is_store, is_br, pred, taken, ready;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;
  bit          e_cv, e_flush;
  logic [4:0]  e_crd;
  logic [31:0] e_cdata, e_fpc;
  int          e_ctag;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0; e_cv = 0; e_flush = 0; e_crd = 0; e_cdata = 0; e_fpc = 0; e_ctag = 0;
  endtask

  function automatic bit model_mis();
    if (mq.size() == 0) return 1'b0;
    return mq[0].ready && mq[0].is_br && !mq[0].is_store && (mq[0].taken != mq[0].pred);
  endfunction

  function automatic bit tag_is_br(input int t);
    foreach (mq[i]) if (mq[i].tag == t && mq[i].is_br) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit   head_ready, can_alloc, pop;
    ent_t ne;
    if (!rdy) begin
      e_cv = 0; e_flush = 0;
      return;
    end
    head_ready = (mq.size() > 0) && mq[0].ready;
    can_alloc  = (mq.size() < DEPTH) && !model_mis();
    if (model_mis()) begin
      e_cv = 1; e_crd = mq[0].rd; e_cdata = mq[0].data; e_ctag = mq[0].tag;
      e_flush = 1; e_fpc = mq[0].npc;
      mq.delete();
      m_tail = 0;
      return;
    end
    e_flush = 0;
    e_cv = head_ready && !mq[0].is_store;
    if (e_cv) begin
      e_crd = mq[0].rd; e_cdata = mq[0].data; e_ctag = mq[0].tag;
    end
    pop = head_ready && (!mq[0].is_store || store_ack);
    foreach (mq[i]) if (wb1_valid && mq[i].tag == int'(wb1_tag)) begin
      mq[i].ready = 1; mq[i].data = wb1_data;
    end
    foreach (mq[i]) if (wb0_valid && mq[i].tag == int'(wb0_tag)) begin
      mq[i].ready = 1; mq[i].data = wb0_data; mq[i].taken = wb0_taken; mq[i].npc = wb0_npc;
    end
    if (pop) void'(mq.pop_front());
    if (alloc_valid && can_alloc) begin
      ne = '{tag: m_tail, rd: alloc_rd, data: 32'h0, npc: 32'h0, is_store: alloc_is_store,
             is_br: alloc_is_br, pred: alloc_pred, taken: 1'b0, ready: 1'b0};
      mq.push_back(ne);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic check_all();
    bit exp_sr;
    exp_sr = (mq.size() > 0) && mq[0].ready && mq[0].is_store;
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("alloc_ready", alloc_ready, (mq.size() < DEPTH) && !model_mis());
    check("alloc_tag", alloc_tag, m_tail);
    check("store_req", store_req, exp_sr);
    if (exp_sr) check("store_tag", store_tag, mq[0].tag);
    check("commit_valid", commit_valid, e_cv);
    if (e_cv) begin
      check("commit_rd", commit_rd, e_crd);
      check("commit_data", commit_data, e_cdata);
      check("commit_tag", commit_tag, e_ctag);
    end
    check("flush", flush, e_flush);
    if (e_flush) check("flush_pc", flush_pc, e_fpc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rdy = 1; alloc_valid = 0; alloc_rd = 0; alloc_is_store = 0; alloc_is_br = 0; alloc_pred = 0;
    wb0_valid = 0; wb0_tag = 0; wb0_data = 0; wb0_taken = 0; wb0_npc = 0;
    wb1_valid = 0; wb1_tag = 0; wb1_data = 0; store_ack = 0;
  endtask

  task automatic set_alloc(input logic [4:0] rd, input bit st, input bit br, input bit pr);
    alloc_valid = 1; alloc_rd = rd; alloc_is_store = st; alloc_is_br = br; alloc_pred = pr;
  endtask

  task automatic set_wb0(input int t, input logic [31:0] d, input bit tk, input logic [31:0] npc);
    wb0_valid = 1; wb0_tag = 3'(t); wb0_data = d; wb0_taken = tk; wb0_npc = npc;
  endtask

  task automatic set_wb1(input int t, input logic [31:0] d);
    wb1_valid = 1; wb1_tag = 3'(t); wb1_data = d;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    drive_idle();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_alloc_ready"}, alloc_ready, 1);
    check({tag, "_alloc_tag"}, alloc_tag, 0);
    check({tag, "_commit_valid"}, commit_valid, 0);
    check({tag, "_commit_fields"}, {commit_rd, commit_tag, commit_data}, 0);
    check({tag, "_store_req"}, store_req, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_flush_pc"}, flush_pc, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int av, rd, st, w0v, w0t, w0d, w1v, w1t, w1d, ack, r;
    int x_count, x_cv, x_cdata, x_sr, x_atag;
  } vec_t;
  vec_t vt[16];

  initial begin
    int idx, r, t;
    drive_idle();
    do_reset();

    //        av rd st w0v w0t w0d  w1v w1t w1d   ack r  | cnt cv cdata  sr atag
    vt[0]  = '{1, 0, 1, 0, 0, 0,    0, 0, 0,     0, 1,   1, 0, 0,     0, 1};
    vt[1]  = '{1, 3, 0, 0, 0, 0,    1, 0, 'h55,  0, 1,   2, 0, 0,     1, 2};
    vt[2]  = '{0, 0, 0, 0, 0, 0,    1, 1, 'h33,  0, 1,   2, 0, 0,     1, 2};
    vt[3]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 1,   2, 0, 0,     1, 2};
    vt[4]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 1,   2, 0, 0,     1, 2};
    vt[5]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 1,   2, 0, 0,     1, 2};
    vt[6]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 1,   2, 0, 0,     1, 2};
    vt[7]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0,     1, 1,   1, 0, 0,     0, 2};
    vt[8]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 1,   0, 1, 'h33,  0, 2};
    vt[9]  = '{1, 5, 0, 0, 0, 0,    0, 0, 0,     0, 1,   1, 0, 0,     0, 3};
    vt[10] = '{0, 0, 0, 1, 2, 'hA,  1, 2, 'hB,   0, 1,   1, 0, 0,     0, 3};
    vt[11] = '{1, 6, 0, 0, 0, 0,    0, 0, 0,     0, 1,   1, 1, 'hA,   0, 4};
    vt[12] = '{0, 0, 0, 0, 0, 0,    1, 3, 'h66,  0, 1,   1, 0, 0,     0, 4};
    vt[13] = '{0, 0, 0, 0, 0, 0,    0, 0, 0,     1, 1,   0, 1, 'h66,  0, 4};
    vt[14] = '{1, 7, 0, 0, 0, 0,    0, 0, 0,     0, 0,   0, 0, 0,     0, 4};
    vt[15] = '{0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 1,   0, 0, 0,     0, 4};

    for (int i = 0; i < 16; i++) begin
      if (vt[i].av != 0) set_alloc(5'(vt[i].rd), vt[i].st != 0, 1'b0, 1'b0);
      if (vt[i].w0v != 0) set_wb0(vt[i].w0t, 32'(vt[i].w0d), 1'b0, 32'h0);
      if (vt[i].w1v != 0) set_wb1(vt[i].w1t, 32'(vt[i].w1d));
      store_ack = (vt[i].ack != 0);
      rdy = (vt[i].r != 0);
      step();
      check("vec_count", count, vt[i].x_count);
      check("vec_commit_valid", commit_valid, vt[i].x_cv);
      if (vt[i].x_cv != 0) check("vec_commit_data", commit_data, vt[i].x_cdata);
      check("vec_store_req", store_req, vt[i].x_sr);
      check("vec_alloc_tag", alloc_tag, vt[i].x_atag);
    end

    // ---------------- fill to full, reverse writeback, in-order drain ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(5'(i + 1), 1'b0, 1'b0, 1'b0);
      step();
    end
    check("full_alloc_ready", alloc_ready, 0);
    check("full_count", count, 8);
    set_alloc(5'd20, 1'b0, 1'b0, 1'b0);
    step();
    check("full_no_alloc_count", count, 8);
    for (int i = 7; i >= 0; i--) begin
      set_wb1(i, 32'h100 + 32'(i + 1));
      step();
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      check("drain_commit_valid", commit_valid, 1);
      check("drain_commit_rd", commit_rd, k);
      check("drain_commit_data", commit_data, 32'h100 + 32'(k));
    end
    check("drain_empty", empty, 1);

    // ---------------- wrap-around: 20 alloc/commit pairs ----------------
    for (int i = 0; i < 20; i++) begin
      check("wrap_alloc_tag", alloc_tag, i % 8);
      set_alloc(5'((i % 31) + 1), 1'b0, 1'b0, 1'b0);
      step();
      set_wb0(i % 8, 32'h200 + 32'(i), 1'b0, 32'h0);
      step();
      step();
      check("wrap_commit_tag", commit_tag, i % 8);
      check("wrap_commit_data", commit_data, 32'h200 + 32'(i));
    end

    // ---------------- mispredict flush ----------------
    set_alloc(5'd1, 1'b0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      set_alloc(5'(i + 2), 1'b0, 1'b0, 1'b0);
      step();
    end
    set_wb0(4, 32'h1004, 1'b1, 32'h1040);
    set_wb1(5, 32'h5);
    step();
    check("mis_detect_alloc_ready", alloc_ready, 0);
    set_alloc(5'd9, 1'b0, 1'b0, 1'b0);
    set_wb1(6, 32'hDEAD);
    set_wb0(7, 32'hBEEF, 1'b0, 32'h0);
    step();
    check("mis_flush", flush, 1);
    check("mis_flush_pc", flush_pc, 32'h1040);
    check("mis_commit_valid", commit_valid, 1);
    check("mis_commit_tag", commit_tag, 4);
    check("mis_commit_rd", commit_rd, 1);
    check("mis_count", count, 0);
    check("mis_alloc_tag", alloc_tag, 0);
    step();
    check("mis_flush_pulse", flush, 0);

    // ---------------- rdy low with a ready head ----------------
    set_alloc(5'd9, 1'b0, 1'b0, 1'b0);
    step();
    set_wb1(0, 32'h77);
    step();
    for (int i = 0; i < 3; i++) begin
      set_alloc(5'd10, 1'b0, 1'b0, 1'b0);
      rdy = 0;
      step();
      check("rdy_low_commit_valid", commit_valid, 0);
      check("rdy_low_count", count, 1);
      check("rdy_low_alloc_tag", alloc_tag, 1);
    end
    step();
    check("rdy_high_commit_data", commit_data, 32'h77);

    // ---------------- asynchronous reset mid-store ----------------
    set_alloc(5'd0, 1'b1, 1'b0, 1'b0);
    step();
    set_wb1(1, 32'h88);
    step();
    check("pre_reset_store_req", store_req, 1);
    rst_n = 0;
    #1;
    model_reset();
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1;
    check_all();

    // ---------------- randomized run against the model ----------------
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 6) begin
        r = $urandom_range(0, 9);
        set_alloc(5'($urandom_range(0, 31)), r < 2, r == 2, $urandom_range(0, 1) != 0);
      end
      if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
        idx = $urandom_range(0, mq.size() - 1);
        if (mq[idx].is_br || $urandom_range(0, 1) != 0)
          set_wb0(mq[idx].tag, $urandom, mq[idx].pred ^ ($urandom_range(0, 3) == 0), $urandom);
        else
          set_wb1(mq[idx].tag, $urandom);
      end
      if (!wb1_valid && $urandom_range(0, 4) == 0) begin
        t = $urandom_range(0, 7);
        if (!tag_is_br(t)) set_wb1(t, $urandom);
      end
      store_ack = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_param.md
# rob_param

Parametrised in-order reorder buffer, successor to the fixed 32-entry ROB. It allocates one entry per cycle from the decode/dispatch stage and accepts results on two writeback ports (ALU/branch and load/store buffer). It retires one instruction per cycle in program order, with a handshaked store release to the store buffer and a branch-mispredict flush that redirects fetch.

## Interface
Parameters:
- DEPTH, 32, number of entries; power of two, 4..64.
- TAG_W, $clog2(DEPTH), entry tag width.
- NAME_W, 5, architectural register name width.
- DATA_W, 32, result width.
- ADDR_W, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state freezes.
- alloc_valid  in  1  dispatch requests a new entry.
- alloc_ready  out  1  entry available; `count < DEPTH` and no flush pending.
- alloc_tag  out  TAG_W  tag given to the entry (the tail pointer).
- alloc_rd  in  NAME_W  destination register.
- alloc_is_store  in  1  entry is SB/SH/SW.
- alloc_is_br  in  1  entry is a conditional branch or JALR.
- alloc_pred  in  1  predicted taken.
- wb0_valid, wb0_tag, wb0_data, wb0_taken, wb0_npc  in  1/TAG_W/DATA_W/1/ADDR_W  ALU/branch result; wb0_npc is the resolved next PC.
- wb1_valid, wb1_tag, wb1_data  in  1/TAG_W/DATA_W  LSB result (load data, or store address/data ready).
- commit_valid  out  1  registered one-cycle retire pulse.
- commit_rd, commit_data, commit_tag  out  NAME_W/DATA_W/TAG_W  retired entry fields.
- store_req  out  1  head store may write memory; level signal.
- store_tag  out  TAG_W  tag of that store.
- store_ack  in  1  store buffer accepted the store.
- flush  out  1  registered one-cycle mispredict pulse.
- flush_pc  out  ADDR_W  redirect PC.
- count  out  TAG_W+1  occupied entries.
- empty  out  1  `count == 0`.

## Operation
- Each entry holds: busy, ready, rd, data, is_store, is_br, pred, taken, npc. head/tail are TAG_W-bit pointers that wrap naturally modulo DEPTH.
- Alloc fires on `alloc_valid && alloc_ready`. The entry at tail is written with busy=1, ready=0. tail increments.
- Writeback sets ready=1 and data on a busy entry. wb0 also writes taken/npc. A writeback to a non-busy tag is ignored. If wb0 and wb1 hit the same tag in the same cycle, wb0 wins.
- Head evaluation is combinational on busy and ready at head:
  - Normal entry, or branch with `taken == pred`: retire at the edge. commit_valid=1 next cycle with the head's rd/data/tag. head increments.
  - Store: store_req=1 and store_tag=head while the store is ready. It retires, without commit_valid, on the edge where `store_ack=1`.
  - Branch with `taken != pred`: at the edge, commit_valid=1 for the branch (its rd is written, which covers JALR). flush=1 and flush_pc=npc. All entries are cleared, head=tail=0, count=0.
- In the mispredict-detect cycle, alloc_ready=0 and both writeback ports are ignored.
- count = count + alloc_fire − retire. Simultaneous alloc and retire leaves count unchanged. A retire does not free space for an alloc in the same cycle.
- rd=0 entries still pulse commit_valid; the register file discards them.

## Timing
- Reset (rst_n low, asynchronous): all entries invalid, head=tail=0, count=0, empty=1, alloc_tag=0, alloc_ready=1. commit_valid, store_req, flush, flush_pc and commit fields are all 0.
- Reset deasserted mid-store or mid-flush: the buffer simply restarts empty.
- Latency: alloc at edge N, writeback at edge N+1 or later. The ready bit is visible from the following cycle. The earliest commit_valid is one cycle after ready is visible. Minimum alloc-to-commit is 3 cycles.
- Store handshake: store_req stays high until the edge where store_ack is sampled. store_ack while store_req=0 is ignored. The next head can be evaluated in the cycle after the ack.
- rdy=0: no state changes. commit_valid and flush drop to 0. store_req holds its value, and store_ack is ignored.
- Full: alloc_ready=0 at count==DEPTH. With DEPTH=32, tags run 0..31 and wrap to 0.

## Test plan
- Reset with DEPTH=8: alloc 8 entries with rd 1..8, writeback in reverse order with data 0x100+rd. Required: alloc_ready=0 after the 8th alloc; commits in order with rd 1..8, one per cycle; empty=1 at the end.
- Wrap-around: run 20 alloc/commit pairs through DEPTH=8. Required: tags sequence 0..7,0..; count never exceeds 8; commit data matches.
- Store: head store ready, hold store_ack low for 5 cycles. Required: store_req held high for 5 cycles, no commit, no head movement. Raise ack: the store retires, the next entry commits one cycle after.
- Mispredict: alloc branch (pred=0), then 3 entries. Writeback branch with taken=1, npc=0x1040. Required: flush=1 with flush_pc=0x1040, count=0 the next cycle, and a younger writeback in the same cycle is dropped.
- Simultaneous: wb0 and wb1 to the same tag with data 0xA and 0xB. Required: commits 0xA. Alloc+retire in the same cycle: count unchanged.
- rdy low for 3 cycles with ready head: no commit and counters frozen. Assert rst_n low mid-run: all outputs at their reset values immediately.
